// File: rtl/bp_be_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : bp_be_instr_encoder
// Purpose : Turns backend micro-op commands into 32-bit RV64I instruction
//           words that are injected into the dispatch path (trap stubs, CSR
//           reads, self-test streams). The LI pseudo-op expands into
//           LUI + ADDIW through a two-state FSM. Commands with an illegal
//           opcode or an out-of-range immediate are consumed, dropped and
//           flagged on err_o. Encoded words leave through a small FIFO with
//           a valid/ready handshake.
// Ports   : clk_i, reset_n_i          clock, async active-low reset
//           cmd_v_i / cmd_ready_o     command handshake
//           cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, cmd_imm_i
//                                     command fields
//           instr_v_o / instr_ready_i output handshake, instr_o head word
//           err_o                     one-cycle pulse for a dropped command
// Revision: 1.0  initial release
// ============================================================================
module bp_be_instr_encoder #(
    parameter int fifo_els_p = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        cmd_v_i,
    output logic        cmd_ready_o,
    input  logic [3:0]  cmd_op_i,
    input  logic [4:0]  cmd_rd_i,
    input  logic [4:0]  cmd_rs1_i,
    input  logic [4:0]  cmd_rs2_i,
    input  logic [31:0] cmd_imm_i,
    output logic        instr_v_o,
    output logic [31:0] instr_o,
    input  logic        instr_ready_i,
    output logic        err_o
);

    localparam int c_ptr_w = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;

    localparam logic [3:0] c_op_add   = 4'd0;
    localparam logic [3:0] c_op_sub   = 4'd1;
    localparam logic [3:0] c_op_addi  = 4'd2;
    localparam logic [3:0] c_op_lui   = 4'd3;
    localparam logic [3:0] c_op_li    = 4'd4;
    localparam logic [3:0] c_op_ld    = 4'd5;
    localparam logic [3:0] c_op_sd    = 4'd6;
    localparam logic [3:0] c_op_beq   = 4'd7;
    localparam logic [3:0] c_op_jal   = 4'd8;
    localparam logic [3:0] c_op_csrrs = 4'd9;
    localparam logic [3:0] c_op_fence = 4'd10;
    localparam logic [3:0] c_op_nop   = 4'd11;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_EMIT_LO = 1'b1
    } state_e;

    state_e              r_state;
    logic [4:0]          r_lo_rd;
    logic [11:0]         r_lo_imm;
    logic [c_ptr_w:0]    r_wptr;
    logic [c_ptr_w:0]    r_rptr;
    logic [31:0]         r_mem [fifo_els_p];
    logic                r_err;

    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_pop;
    logic                w_push_cmd;
    logic                w_push_lo;
    logic                w_push;
    logic [31:0]         w_push_data;

    logic signed [31:0]  w_simm;
    logic                w_imm12_ok;
    logic                w_br_ok;
    logic                w_jal_ok;
    logic [19:0]         w_li_hi;
    logic [31:0]         w_enc_word;
    logic                w_enc_ok;
    logic                w_li_split;

    // ------------------------------------------------------------------
    // FIFO status: full when only the wrap bits differ
    // ------------------------------------------------------------------
    assign w_full  = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                     (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    assign cmd_ready_o = (r_state == ST_IDLE) && !w_full;
    assign instr_v_o   = !w_empty;
    assign instr_o     = w_empty ? 32'h0 : r_mem[r_rptr[c_ptr_w-1:0]];
    assign err_o       = r_err;

    assign w_accept = cmd_v_i && cmd_ready_o;
    assign w_pop    = instr_v_o && instr_ready_i;

    // ------------------------------------------------------------------
    // Immediate range checks
    // ------------------------------------------------------------------
    assign w_simm     = $signed(cmd_imm_i);
    assign w_imm12_ok = (w_simm >= -32'sd2048) && (w_simm <= 32'sd2047);
    assign w_br_ok    = (w_simm >= -32'sd4096) && (w_simm <= 32'sd4094) && !cmd_imm_i[0];
    assign w_jal_ok   = (w_simm >= -32'sd1048576) && (w_simm <= 32'sd1048574) && !cmd_imm_i[0];

    // (imm + 0x800) >> 12: adding 0x800 carries into bit 12 exactly when
    // imm[11] is set, so the upper part is imm[31:12] + imm[11] (mod 2^20).
    // This rounds hi so that the sign-extended lo[11:0] corrects it back.
    assign w_li_hi = cmd_imm_i[31:12] + {19'd0, cmd_imm_i[11]};

    // ------------------------------------------------------------------
    // Command encoder
    // ------------------------------------------------------------------
    always_comb begin
        w_enc_word = 32'h0;
        w_enc_ok   = 1'b1;
        w_li_split = 1'b0;
        case (cmd_op_i)
            c_op_add:   w_enc_word = {7'b0000000, cmd_rs2_i, cmd_rs1_i, 3'b000, cmd_rd_i, 7'b0110011};
            c_op_sub:   w_enc_word = {7'b0100000, cmd_rs2_i, cmd_rs1_i, 3'b000, cmd_rd_i, 7'b0110011};
            c_op_addi: begin
                w_enc_ok   = w_imm12_ok;
                w_enc_word = {cmd_imm_i[11:0], cmd_rs1_i, 3'b000, cmd_rd_i, 7'b0010011};
            end
            c_op_lui: begin
                w_enc_ok   = (cmd_imm_i[31:20] == 12'h000);
                w_enc_word = {cmd_imm_i[19:0], cmd_rd_i, 7'b0110111};
            end
            c_op_li: begin
                if (w_imm12_ok) begin
                    w_enc_word = {cmd_imm_i[11:0], 5'd0, 3'b000, cmd_rd_i, 7'b0010011};
                end else begin
                    w_enc_word = {w_li_hi, cmd_rd_i, 7'b0110111};
                    // A zero low part needs no ADDIW correction
                    w_li_split = (cmd_imm_i[11:0] != 12'h000);
                end
            end
            c_op_ld: begin
                w_enc_ok   = w_imm12_ok;
                w_enc_word = {cmd_imm_i[11:0], cmd_rs1_i, 3'b011, cmd_rd_i, 7'b0000011};
            end
            c_op_sd: begin
                w_enc_ok   = w_imm12_ok;
                w_enc_word = {cmd_imm_i[11:5], cmd_rs2_i, cmd_rs1_i, 3'b011,
                              cmd_imm_i[4:0], 7'b0100011};
            end
            c_op_beq: begin
                w_enc_ok   = w_br_ok;
                w_enc_word = {cmd_imm_i[12], cmd_imm_i[10:5], cmd_rs2_i, cmd_rs1_i, 3'b000,
                              cmd_imm_i[4:1], cmd_imm_i[11], 7'b1100011};
            end
            c_op_jal: begin
                w_enc_ok   = w_jal_ok;
                w_enc_word = {cmd_imm_i[20], cmd_imm_i[10:1], cmd_imm_i[11],
                              cmd_imm_i[19:12], cmd_rd_i, 7'b1101111};
            end
            c_op_csrrs: w_enc_word = {cmd_imm_i[11:0], 5'd0, 3'b010, cmd_rd_i, 7'b1110011};
            c_op_fence: w_enc_word = 32'h0ff0000f;
            c_op_nop:   w_enc_word = 32'h00000013;
            default:    w_enc_ok   = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO push selection; the two sources are exclusive because new
    // commands are only accepted in IDLE
    // ------------------------------------------------------------------
    assign w_push_cmd  = w_accept && w_enc_ok;
    assign w_push_lo   = (r_state == ST_EMIT_LO) && !w_full;
    assign w_push      = w_push_cmd || w_push_lo;
    assign w_push_data = w_push_lo ? {r_lo_imm, r_lo_rd, 3'b000, r_lo_rd, 7'b0011011}
                                   : w_enc_word;

    // ------------------------------------------------------------------
    // Control state: FSM, pointers, error pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state  <= ST_IDLE;
            r_lo_rd  <= 5'd0;
            r_lo_imm <= 12'h000;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_err <= w_accept && !w_enc_ok;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_li_split) begin
                        r_state  <= ST_EMIT_LO;
                        r_lo_rd  <= cmd_rd_i;
                        r_lo_imm <= cmd_imm_i[11:0];
                    end
                end
                ST_EMIT_LO: begin
                    if (!w_full) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr[c_ptr_w-1:0]] <= w_push_data;
    end

endmodule
`default_nettype wire

// File: tb/tb_bp_be_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_bp_be_instr_encoder
// Purpose : Self-checking bench for bp_be_instr_encoder. A reference model
//           computes the instruction words for each accepted command and a
//           monitor compares them with what the FIFO presents.
// Revision: 1.0  initial release
// ============================================================================
module tb_bp_be_instr_encoder;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        cmd_v_i = 1'b0;
    logic        cmd_ready_o;
    logic [3:0]  cmd_op_i = 4'd0;
    logic [4:0]  cmd_rd_i = 5'd0;
    logic [4:0]  cmd_rs1_i = 5'd0;
    logic [4:0]  cmd_rs2_i = 5'd0;
    logic [31:0] cmd_imm_i = 32'h0;
    logic        instr_v_o;
    logic [31:0] instr_o;
    logic        instr_ready_i = 1'b0;
    logic        err_o;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          exp_err = 1'b0;
    bit          rand_rdy = 1'b0;
    logic [31:0] exp_q[$];

    bp_be_instr_encoder #(.fifo_els_p(2)) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .cmd_v_i      (cmd_v_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_rd_i     (cmd_rd_i),
        .cmd_rs1_i    (cmd_rs1_i),
        .cmd_rs2_i    (cmd_rs2_i),
        .cmd_imm_i    (cmd_imm_i),
        .instr_v_o    (instr_v_o),
        .instr_o      (instr_o),
        .instr_ready_i(instr_ready_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: RV64I field layouts built with plain shifts/masks
    function automatic void model(input logic [31:0] op, input logic [31:0] rd,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] u, output bit err, output int n,
                                  output logic [31:0] w0, output logic [31:0] w1);
        int s;
        logic [31:0] hi;
        logic [31:0] lo;
        s   = $signed(u);
        err = 1'b0;
        n   = 1;
        w0  = 32'h0;
        w1  = 32'h0;
        case (op)
            0:  w0 = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
            1:  w0 = 32'h40000000 | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
            2:  if (s >= -2048 && s <= 2047) w0 = ((u & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
                else err = 1'b1;
            3:  if ((u >> 20) == 0) w0 = (u << 12) | (rd << 7) | 32'h37;
                else err = 1'b1;
            4: begin
                if (s >= -2048 && s <= 2047) begin
                    w0 = ((u & 32'hFFF) << 20) | (rd << 7) | 32'h13;
                end else begin
                    hi = ((u + 32'h800) >> 12) & 32'hFFFFF;
                    lo = u & 32'hFFF;
                    w0 = (hi << 12) | (rd << 7) | 32'h37;
                    if (lo != 0) begin
                        n  = 2;
                        w1 = (lo << 20) | (rd << 15) | (rd << 7) | 32'h1B;
                    end
                end
            end
            5:  if (s >= -2048 && s <= 2047)
                    w0 = ((u & 32'hFFF) << 20) | (rs1 << 15) | (3 << 12) | (rd << 7) | 32'h03;
                else err = 1'b1;
            6:  if (s >= -2048 && s <= 2047)
                    w0 = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (3 << 12) |
                         ((u & 32'h1F) << 7) | 32'h23;
                else err = 1'b1;
            7:  if (s >= -4096 && s <= 4094 && (u & 1) == 0)
                    w0 = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) |
                         (rs1 << 15) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
                else err = 1'b1;
            8:  if (s >= -1048576 && s <= 1048574 && (u & 1) == 0)
                    w0 = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
                         (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
                else err = 1'b1;
            9:  w0 = ((u & 32'hFFF) << 20) | (2 << 12) | (rd << 7) | 32'h73;
            10: w0 = 32'h0ff0000f;
            11: w0 = 32'h00000013;
            default: err = 1'b1;
        endcase
        if (err) n = 0;
    endfunction

    // Scoreboard producer: every accepted command pushes its expected words
    always @(posedge clk_i) begin
        bit          e;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        if (!reset_n_i) begin
            exp_err = 1'b0;
        end else if (cmd_v_i && cmd_ready_o) begin
            model(32'(cmd_op_i), 32'(cmd_rd_i), 32'(cmd_rs1_i), 32'(cmd_rs2_i), cmd_imm_i,
                  e, n, w0, w1);
            exp_err = e;
            if (n >= 1) exp_q.push_back(w0);
            if (n == 2) exp_q.push_back(w1);
        end else begin
            exp_err = 1'b0;
        end
    end

    // Reset discards everything in flight
    always @(negedge reset_n_i) begin
        exp_q.delete();
        exp_err = 1'b0;
    end

    // Monitor: compare on the opposite edge
    always @(negedge clk_i) begin
        logic [31:0] w;
        if (reset_n_i) begin
            chk("err_o", 32'(err_o), 32'(exp_err));
            if (instr_v_o && instr_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected none at %0t", instr_o, $time);
                end else begin
                    w = exp_q.pop_front();
                    chk("instr_o", instr_o, w);
                end
            end
        end
    end

    task automatic drive_cmd(input int op, input int rd, input int rs1, input int rs2,
                             input logic [31:0] imm);
        cmd_op_i  = 4'(op);
        cmd_rd_i  = 5'(rd);
        cmd_rs1_i = 5'(rs1);
        cmd_rs2_i = 5'(rs2);
        cmd_imm_i = imm;
        cmd_v_i   = 1'b1;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            if (cmd_ready_o) begin
                @(posedge clk_i);
                #1;
                cmd_v_i = 1'b0;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL cmd_accept_timeout: got no acceptance expected acceptance within 300 cycles");
        cmd_v_i = 1'b0;
    endtask

    task automatic send_cmd(input int op, input int rd, input int rs1, input int rs2,
                            input logic [31:0] imm);
        drive_cmd(op, rd, rs1, rs2, imm);
        wait_accept();
    endtask

    function automatic logic [31:0] pick_imm();
        int bnd[20] = '{-2048, 2047, 2048, -2049, 4094, 4095, -4096, -4098, 4096, 1048574,
                        1048575, -1048576, -1048578, 1048576, 32'h7FF, 32'h800,
                        32'hFFFFF800, 32'hFFFFF7FF, 0, 1};
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       v = bnd[$urandom_range(0, 19)];
            2:       v = $urandom;
            3:       v = $urandom & 32'h000FFFFF;
            4:       v = 32'($urandom_range(0, 4194303)) - 32'd2097152;
            default: v = $urandom & 32'hFFFFF000;
        endcase
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_instr_v", 32'(instr_v_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_err", 32'(err_o), 32'd0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);

        // ADD into empty FIFO: visible the cycle after acceptance
        instr_ready_i = 1'b1;
        send_cmd(0, 3, 1, 2, 32'h0);
        chk("t1_valid", 32'(instr_v_o), 32'd1);
        chk("t1_word", instr_o, 32'h002081B3);

        // LI split into LUI + ADDIW
        send_cmd(4, 5, 0, 0, 32'h12345FFF);
        chk("t2_lui", instr_o, 32'h123462B7);
        chk("t2_ready_low", 32'(cmd_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("t2_addiw", instr_o, 32'hFFF2829B);
        chk("t2_ready_back", 32'(cmd_ready_o), 32'd1);

        // LI single-instruction forms
        send_cmd(4, 5, 0, 0, 32'h000007FF);
        chk("t3_addi", instr_o, 32'h7FF00293);
        chk("t3_ready_a", 32'(cmd_ready_o), 32'd1);
        send_cmd(4, 6, 0, 0, 32'h00010000);
        chk("t3_lui", instr_o, 32'h00010337);
        chk("t3_ready_b", 32'(cmd_ready_o), 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
        chk("t3_no_addiw", 32'(instr_v_o), 32'd0);

        // Range violation and illegal opcode
        send_cmd(2, 1, 1, 0, 32'd2048);
        chk("t4_err_a", 32'(err_o), 32'd1);
        chk("t4_ready_a", 32'(cmd_ready_o), 32'd1);
        send_cmd(13, 1, 1, 0, 32'd0);
        chk("t4_err_b", 32'(err_o), 32'd1);
        @(posedge clk_i);
        #1;
        chk("t4_err_clear", 32'(err_o), 32'd0);
        chk("t4_fifo_empty", 32'(instr_v_o), 32'd0);
        chk("t4_ready_b", 32'(cmd_ready_o), 32'd1);

        // Backpressure with a full FIFO
        instr_ready_i = 1'b0;
        send_cmd(11, 0, 0, 0, 32'h0);
        send_cmd(11, 0, 0, 0, 32'h0);
        chk("t5_full", 32'(cmd_ready_o), 32'd0);
        drive_cmd(11, 0, 0, 0, 32'h0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("t5_held", 32'(cmd_ready_o), 32'd0);
        chk("t5_head", instr_o, 32'h00000013);
        instr_ready_i = 1'b1;
        wait_accept();
        repeat (6) @(posedge clk_i);
        #1;
        chk("t5_drained", 32'(instr_v_o), 32'd0);

        // Reset while ADDIW is pending
        instr_ready_i = 1'b0;
        send_cmd(11, 0, 0, 0, 32'h0);
        send_cmd(4, 7, 0, 0, 32'h12345678);
        repeat (2) @(posedge clk_i);
        #1;
        chk("t6_wait_ready", 32'(cmd_ready_o), 32'd0);
        chk("t6_wait_valid", 32'(instr_v_o), 32'd1);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("t6_async_valid", 32'(instr_v_o), 32'd0);
        chk("t6_async_instr", instr_o, 32'h0);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        instr_ready_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        chk("t6_no_addiw", 32'(instr_v_o), 32'd0);
        chk("t6_ready", 32'(cmd_ready_o), 32'd1);

        // Randomized traffic with random consumer backpressure
        rand_rdy = 1'b1;
        fork
            begin
                while (rand_rdy) begin
                    @(posedge clk_i);
                    #1;
                    if (rand_rdy) instr_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int k = 0; k < 400; k++) begin
            send_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), pick_imm());
            if ($urandom_range(0, 3) == 0) @(posedge clk_i);
        end
        rand_rdy = 1'b0;
        @(posedge clk_i);
        #2;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() != 0 || instr_v_o); i++) @(posedge clk_i);
        #1;
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(instr_v_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
